// File: rtl/pipelined_multiplier_pkg.sv
// Shared types and helpers for the pipelined array multiplier stages.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipelined_multiplier_pkg;

  // Widest result word the merge helper can handle.
  localparam int unsigned MAX_RESULT_W = 64;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Replace the per_stage-wide field at stage_index*per_stage in low with bits.
  // Bits of 'bits' above per_stage are ignored.
  function automatic logic [MAX_RESULT_W-1:0] merge_result_bits(
    input logic [MAX_RESULT_W-1:0] low,
    input logic [MAX_RESULT_W-1:0] bits,
    input int unsigned             stage_index,
    input int unsigned             per_stage
  );
    logic [MAX_RESULT_W-1:0] mask;
    int unsigned             lsb;
    lsb  = stage_index * per_stage;
    mask = ((MAX_RESULT_W'(1) << per_stage) - MAX_RESULT_W'(1)) << lsb;
    return (low & ~mask) | ((bits << lsb) & mask);
  endfunction

endpackage

// File: rtl/pipeline_skid_buffer.sv
// Generic two-entry valid/ready skid buffer; main register drives data_o.
// Latency: 1 cycle from accept to valid_o; sustains 1 entry per cycle.
// Backpressure: ready_o comes straight from the state register (low only when FULL).
module pipeline_skid_buffer
  import pipelined_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             consume;

  // Handshake flags are decoded from registered state only.
  assign valid_o = (state_q != EMPTY);
  assign ready_o = (state_q != FULL);
  assign data_o  = main_q;
  assign accept  = valid_i && ready_o;
  assign consume = valid_o && ready_i;

  // Occupancy register and the two payload slots.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and slot steering; a flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (clear_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = data_i;
          end else if (accept) begin
            skid_d  = data_i;
            state_d = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // ready_o is low here, so only a consume can happen.
          if (consume) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_array_multiplier_pipe_reg.sv
// Pipeline register after one array-multiplier stage: shifts B, merges result bits, skids.
// Latency: 1 cycle from accept to valid_o; full throughput when downstream is ready.
// Backpressure: absorbs one extra entry; ready_o is registered, no ready_i->ready_o path.
module pipelined_array_multiplier_pipe_reg
  import pipelined_multiplier_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned PRODUCT_PER_STAGE = 4,
  parameter int unsigned STAGE_INDEX       = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_WIDTH-1:0]        operand_A_i,
  input  logic [DATA_WIDTH-1:0]        operand_B_i,
  input  logic [DATA_WIDTH-2:0]        partial_product_i,
  input  logic                         carry_i,
  input  logic [PRODUCT_PER_STAGE-1:0] result_bits_i,
  input  logic [DATA_WIDTH-1:0]        low_result_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DATA_WIDTH-1:0]        operand_A_o,
  output logic [DATA_WIDTH-1:0]        operand_B_o,
  output logic [DATA_WIDTH-2:0]        partial_product_o,
  output logic                         carry_o,
  output logic [DATA_WIDTH-1:0]        low_result_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] operand_A;
    logic [DATA_WIDTH-1:0] operand_B;
    logic [DATA_WIDTH-2:0] partial_product;
    logic                  carry;
    logic [DATA_WIDTH-1:0] low_result;
  } stage_payload_t;

  localparam int unsigned PAYLOAD_W = $bits(stage_payload_t);

  stage_payload_t          in_payload;
  stage_payload_t          out_payload;
  logic [MAX_RESULT_W-1:0] merged_wide;

  // Transform on the input side so both skid slots hold finished payloads.
  always_comb begin
    merged_wide = merge_result_bits(MAX_RESULT_W'(low_result_i),
                                    MAX_RESULT_W'(result_bits_i),
                                    STAGE_INDEX, PRODUCT_PER_STAGE);
    in_payload                 = '0;
    in_payload.operand_A       = operand_A_i;
    in_payload.operand_B       = operand_B_i >> PRODUCT_PER_STAGE;
    in_payload.partial_product = partial_product_i;
    in_payload.carry           = carry_i;
    in_payload.low_result      = merged_wide[DATA_WIDTH-1:0];
  end

  // Bits above DATA_WIDTH are always zero-extended input; nothing reads them.
  if (DATA_WIDTH < MAX_RESULT_W) begin : g_merge_hi
    logic unused_merge_hi;
    assign unused_merge_hi = ^merged_wide[MAX_RESULT_W-1:DATA_WIDTH];
  end

  pipeline_skid_buffer #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (in_payload),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (out_payload)
  );

  assign operand_A_o       = out_payload.operand_A;
  assign operand_B_o       = out_payload.operand_B;
  assign partial_product_o = out_payload.partial_product;
  assign carry_o           = out_payload.carry;
  assign low_result_o      = out_payload.low_result;

endmodule

// File: tb/tb_pipelined_array_multiplier_pipe_reg.sv
// Directed bench for the multiplier pipeline register (stage 1 plus a stage-0 instance).
// Latency: drives and samples on the falling edge, one cycle per step.
// Backpressure: exercised with held, released and random ready_i.
module tb_pipelined_array_multiplier_pipe_reg;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clear_i;

  // Stage-1 instance signals
  logic       valid_i, ready_o, valid_o, ready_i, carry_i, carry_o;
  logic [7:0] a_i, b_i, low_i, a_o, b_o, low_o;
  logic [6:0] pp_i, pp_o;
  logic [3:0] bits_i;

  // Stage-0 instance signals
  logic       valid0_i, ready0_o, valid0_o, ready0_i, carry0_o;
  logic [7:0] low0_i, a0_o, b0_o, low0_o;
  logic [6:0] pp0_o;
  logic [3:0] bits0_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  pipelined_array_multiplier_pipe_reg #(
    .DATA_WIDTH(8), .PRODUCT_PER_STAGE(4), .STAGE_INDEX(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .operand_A_i(a_i), .operand_B_i(b_i), .partial_product_i(pp_i),
    .carry_i(carry_i), .result_bits_i(bits_i), .low_result_i(low_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .operand_A_o(a_o), .operand_B_o(b_o), .partial_product_o(pp_o),
    .carry_o(carry_o), .low_result_o(low_o)
  );

  pipelined_array_multiplier_pipe_reg #(
    .DATA_WIDTH(8), .PRODUCT_PER_STAGE(4), .STAGE_INDEX(0)
  ) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .valid_i(valid0_i), .ready_o(ready0_o),
    .operand_A_i(8'h12), .operand_B_i(8'h34), .partial_product_i(7'h56),
    .carry_i(1'b0), .result_bits_i(bits0_i), .low_result_i(low0_i),
    .valid_o(valid0_o), .ready_i(ready0_i),
    .operand_A_o(a0_o), .operand_B_o(b0_o), .partial_product_o(pp0_o),
    .carry_o(carry0_o), .low_result_o(low0_o)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [6:0] pp,
                       input logic c, input logic [3:0] bits, input logic [7:0] low);
    valid_i = 1'b1;
    a_i = a; b_i = b; pp_i = pp; carry_i = c; bits_i = bits; low_i = low;
  endtask

  // Streaming scoreboard
  logic [7:0] q_low[$];
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  initial begin
    int         sent, rcvd, cyc;
    logic       rdy_before;
    logic [7:0] sa, sb, sl;
    logic [3:0] sbits;

    rst_i = 1'b1; clear_i = 1'b0;
    valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; pp_i = '0; carry_i = 1'b0; bits_i = '0; low_i = '0;
    valid0_i = 1'b0; ready0_i = 1'b1; bits0_i = '0; low0_i = '0;

    // Reset state
    step();
    check("rst_valid", 16'(valid_o), 16'd0);
    check("rst_ready", 16'(ready_o), 16'd1);
    check("rst_low",   16'(low_o),   16'h00);
    check("rst_a",     16'(a_o),     16'h00);
    rst_i = 1'b0;

    // Single transfer, plus the stage-0 merge on the second instance
    step();
    ready_i = 1'b1;
    drive(8'hA5, 8'hC3, 7'h55, 1'b1, 4'hA, 8'h03);
    valid0_i = 1'b1; bits0_i = 4'hF; low0_i = 8'hF0;
    step();
    valid_i = 1'b0; valid0_i = 1'b0;
    check("single_valid", 16'(valid_o), 16'd1);
    check("single_a",     16'(a_o),     16'hA5);
    check("single_b",     16'(b_o),     16'h0C);
    check("single_pp",    16'(pp_o),    16'h55);
    check("single_carry", 16'(carry_o), 16'd1);
    check("single_low",   16'(low_o),   16'hA3);
    check("s0_valid",     16'(valid0_o), 16'd1);
    check("s0_low",       16'(low0_o),   16'hFF);
    check("s0_b",         16'(b0_o),     16'h03);
    step();
    check("single_drain", 16'(valid_o), 16'd0);

    // Stall: two entries land in main and skid
    ready_i = 1'b0;
    drive(8'h11, 8'h00, 7'h00, 1'b0, 4'h1, 8'h01);
    step();
    check("stall1_ready", 16'(ready_o), 16'd1);
    check("stall1_low",   16'(low_o),   16'h11);
    drive(8'h22, 8'h00, 7'h00, 1'b0, 4'h2, 8'h02);
    step();
    valid_i = 1'b0;
    check("stall2_ready", 16'(ready_o), 16'd0);
    check("stall2_valid", 16'(valid_o), 16'd1);
    check("stall2_low",   16'(low_o),   16'h11);
    rdy_before = ready_o;
    ready_i = 1'b1; #1;
    check("full_rdy_indep", 16'(ready_o), 16'(rdy_before));
    ready_i = 1'b0;
    step();
    check("stall_hold_low", 16'(low_o), 16'h11);
    check("stall_hold_a",   16'(a_o),   16'h11);
    ready_i = 1'b1;
    step();
    check("drain1_low",   16'(low_o),   16'h22);
    check("drain1_valid", 16'(valid_o), 16'd1);
    check("drain1_ready", 16'(ready_o), 16'd1);
    step();
    check("drain2_valid", 16'(valid_o), 16'd0);

    // Streaming with random backpressure
    sent = 0; rcvd = 0; cyc = 0;
    while ((sent < 16 || rcvd < 16) && cyc < 400) begin
      step();
      cyc++;
      rdy_before = ready_o;
      ready_i = ~ready_i; #1;
      check("stream_rdy_indep", 16'(ready_o), 16'(rdy_before));
      ready_i = 1'($urandom_range(0, 1));
      sa    = 8'(sent * 13 + 1);
      sb    = 8'(sent * 29 + 7);
      sl    = 8'(sent * 37 + 5);
      sbits = 4'(sent + 3);
      if (sent < 16) drive(sa, sb, 7'(sent), sent[0], sbits, sl);
      else valid_i = 1'b0;
      if (valid_o && ready_i) begin
        if (q_low.size() == 0) begin
          check("stream_extra", 16'd1, 16'd0);
        end else begin
          check("stream_low", 16'(low_o), 16'(q_low.pop_front()));
          check("stream_a",   16'(a_o),   16'(q_a.pop_front()));
          check("stream_b",   16'(b_o),   16'(q_b.pop_front()));
        end
        rcvd++;
      end
      if (valid_i && ready_o) begin
        q_low.push_back({sbits, sl[3:0]});
        q_a.push_back(sa);
        q_b.push_back({4'h0, sb[7:4]});
        sent++;
      end
    end
    check("stream_rcvd", 16'(rcvd), 16'd16);
    valid_i = 1'b0; ready_i = 1'b1;
    step();
    check("stream_empty", 16'(valid_o), 16'd0);

    // Async reset while FULL
    ready_i = 1'b0;
    drive(8'h33, 8'hFF, 7'h7F, 1'b1, 4'h3, 8'h33);
    step();
    drive(8'h44, 8'hFF, 7'h7F, 1'b1, 4'h4, 8'h44);
    step();
    valid_i = 1'b0;
    check("pre_rst_ready", 16'(ready_o), 16'd0);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", 16'(valid_o), 16'd0);
    check("arst_ready", 16'(ready_o), 16'd1);
    check("arst_low",   16'(low_o),   16'h00);
    check("arst_b",     16'(b_o),     16'h00);
    check("arst_carry", 16'(carry_o), 16'd0);
    step();
    rst_i = 1'b0;
    ready_i = 1'b1;
    step();
    step();
    check("post_rst_valid", 16'(valid_o), 16'd0);

    // Flush in ONE while an accept is offered
    ready_i = 1'b0;
    drive(8'h55, 8'h00, 7'h00, 1'b0, 4'h5, 8'h05);
    step();
    check("clr_pre_valid", 16'(valid_o), 16'd1);
    drive(8'h66, 8'h00, 7'h00, 1'b0, 4'h6, 8'h06);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    check("clr_valid", 16'(valid_o), 16'd0);
    check("clr_ready", 16'(ready_o), 16'd1);
    step();
    check("clr_dropped", 16'(valid_o), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
